// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store bus sequencer; define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] aluout,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, next;
  logic [7:0]  cnt;
  logic [1:0]  lo;
  logic [2:0]  f3;
  logic        we, flt, bad, mis, skip, tmo;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ext;
  // Request classification, lane extraction and next-state selection
  always_comb begin
    bad = is_store ? (funct3[2] || funct3[1:0] == 2'b11) : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (funct3[1:0] == 2'b01 && aluout[0]) || (funct3[1:0] == 2'b10 && aluout[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    skip = bad || mis;
    tmo = cnt == 8'(TIMEOUT - 1);
    rbyte = mem_rdata[{lo, 3'b000} +: 8];
    rhalf = mem_rdata[{lo[1], 4'b0000} +: 16];
    ext = f3 == 3'b000 ? {{24{rbyte[7]}}, rbyte} :
          f3 == 3'b001 ? {{16{rhalf[15]}}, rhalf} :
          f3 == 3'b100 ? {24'd0, rbyte} :
          f3 == 3'b101 ? {16'd0, rhalf} : mem_rdata;
    next = state;
    case (state)
      IDLE:    next = start ? (skip ? RESP : ACCESS) : IDLE;
      ACCESS:  next = (mem_ack || tmo) ? RESP : ACCESS;
      default: next = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  // Request latch, wait counter, fault flag and load result capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      we        <= 1'b0;
      f3        <= '0;
      lo        <= '0;
      flt       <= 1'b0;
      cnt       <= '0;
      load_data <= '0;
    end else begin
      cnt <= (state == ACCESS && !mem_ack) ? cnt + 8'd1 : 8'd0;
      if (state == IDLE && start) begin
        mem_addr  <= {aluout[31:2], 2'b00};
        mem_be    <= funct3[1:0] == 2'b00 ? 4'b0001 << aluout[1:0] :
                     funct3[1:0] == 2'b01 ? 4'b0011 << {aluout[1], 1'b0} : 4'b1111;
        mem_wdata <= funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
                     funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
        we        <= is_store;
        f3        <= funct3;
        lo        <= aluout[1:0];
        flt       <= skip;
      end
      if (state == ACCESS) begin
        flt <= !mem_ack && tmo;
        if (mem_ack && !we) load_data <= ext;
      end
    end
  assign mem_req = state == ACCESS;
  assign mem_we  = mem_req && we;
  assign busy    = state != IDLE;
  assign done    = state == RESP;
  assign fault   = done && flt;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store transactions checked against a byte-lane model every cycle
module tb_load_store_unit;
  localparam int TO = 4;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, is_store = 1'b0, mem_ack = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] aluout = '0, store_data = '0, mem_rdata = '0;
  logic        mem_req, mem_we, busy, done, fault;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [3:0]  mem_be;
  int checks = 0, errors = 0;
  logic        chk_en = 1'b0;
  logic        e_busy = 0, e_req = 0, e_done = 0, e_fault = 0, e_we = 0;
  logic [31:0] e_ld = 0, e_addr = 0, e_wd = 0;
  logic [3:0]  e_be = 0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .funct3(funct3),
    .aluout(aluout), .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .load_data(load_data), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison against the model's expected bus/handshake view
  always @(negedge clk) if (chk_en) begin
    check("busy", 32'(busy), 32'(e_busy));
    check("mem_req", 32'(mem_req), 32'(e_req));
    check("done", 32'(done), 32'(e_done));
    check("fault", 32'(fault), 32'(e_fault));
    check("load_data", load_data, e_ld);
    if (e_req) begin
      check("mem_addr", mem_addr, e_addr);
      check("mem_be", 32'(mem_be), 32'(e_be));
      check("mem_wdata", mem_wdata, e_wd);
      check("mem_we", 32'(mem_we), 32'(e_we));
    end
  end

  task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                        input int dly, input logic [31:0] rd, input logic lit,
                        input logic [31:0] l_addr, input logic [3:0] l_be, input logic [31:0] l_wd);
    bit valid, skip;
    int n, off;
    logic [3:0]  be;
    logic [31:0] wd, ld;
    valid = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n = 1 << f3[1:0];
    skip = !valid;
`ifdef LSU_MISALIGN_TRAP_EN
    if (valid && (int'(a[1:0]) % n) != 0) skip = 1;
`endif
    off = valid ? int'(a[1:0]) - (int'(a[1:0]) % n) : 0;
    be = '0; wd = '0; ld = '0;
    if (valid) begin
      for (int j = 0; j < 4; j++) begin
        be[j] = (j >= off) && (j < off + n);
        wd[8*j +: 8] = sd[8*(j % n) +: 8];
      end
      for (int k = 0; k < n; k++) ld[8*k +: 8] = rd[8*(off + k) +: 8];
      if (!f3[2] && n < 4 && rd[8*(off + n) - 1]) ld = ld | (32'hFFFFFFFF << (8 * n));
    end
    start = 1; is_store = st; funct3 = f3; aluout = a; store_data = sd;
    @(posedge clk); #1;
    start = 0; aluout = $urandom; store_data = $urandom; funct3 = 3'($urandom); is_store = 1'($urandom);
    e_busy = 1;
    if (skip) begin
      e_done = 1; e_fault = 1;
    end else begin
      e_req = 1; e_addr = {a[31:2], 2'b00}; e_be = be; e_wd = wd; e_we = st;
      for (int i = 0; i < TO; i++) begin
        mem_ack = (i == dly);
        mem_rdata = (i == dly) ? rd : $urandom;
        if (i > 0) start = 1;
        if (lit && i == 0) begin
          @(negedge clk);
          check("lit_addr", mem_addr, l_addr);
          check("lit_be", 32'(mem_be), 32'(l_be));
          check("lit_wdata", mem_wdata, l_wd);
        end
        @(posedge clk); #1;
        mem_ack = 0; start = 0;
        if (i == dly) begin
          if (!st) e_ld = ld;
          break;
        end
        if (i == TO - 1) e_fault = 1;
      end
      e_req = 0; e_done = 1;
    end
    @(posedge clk); #1;
    e_done = 0; e_fault = 0; e_busy = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_req", 32'(mem_req), 0);
    check("rst_done", 32'(done), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_addr", mem_addr, 0);
    check("rst_be", 32'(mem_be), 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_ld", load_data, 0);
    rst_n = 1; chk_en = 1;
    do_txn(1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 0, 1, 32'h104, 4'b1111, 32'hDEADBEEF);
    do_txn(1, 3'b000, 32'h203, 32'h000000A5, 2, 0, 1, 32'h200, 4'b1000, 32'hA5A5A5A5);
    do_txn(0, 3'b000, 32'h102, 0, 0, 32'h0080FF00, 0, 0, 0, 0);
    check("lit_lb", load_data, 32'hFFFFFF80);
    do_txn(0, 3'b100, 32'h102, 0, 1, 32'h0080FF00, 0, 0, 0, 0);
    check("lit_lbu", load_data, 32'h00000080);
    do_txn(0, 3'b101, 32'h102, 0, 3, 32'h0080FF00, 0, 0, 0, 0);
    check("lit_lhu", load_data, 32'h00000080);
    do_txn(0, 3'b001, 32'h100, 0, 0, 32'h12348001, 0, 0, 0, 0);
    check("lit_lh", load_data, 32'hFFFF8001);
    do_txn(1, 3'b001, 32'h106, 32'h1234BEEF, 1, 0, 1, 32'h104, 4'b1100, 32'hBEEFBEEF);
    do_txn(0, 3'b010, 32'h300, 0, 99, 32'h0, 0, 0, 0, 0);
    check("lit_timeout_ld", load_data, 32'hFFFF8001);
    do_txn(0, 3'b011, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    do_txn(1, 3'b100, 32'h100, 32'h55, 0, 0, 0, 0, 0, 0);
    do_txn(0, 3'b010, 32'h101, 0, 0, 32'hCAFEF00D, 0, 0, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lit_misalign_ld", load_data, 32'hFFFF8001);
`else
    check("lit_misalign_ld", load_data, 32'hCAFEF00D);
`endif
    repeat (2) begin
      mem_ack = 1; mem_rdata = $urandom;
      @(posedge clk); #1;
    end
    mem_ack = 0;
    start = 1; is_store = 0; funct3 = 3'b010; aluout = 32'h400;
    @(posedge clk); #1;
    start = 0; chk_en = 0;
    check("pre_rst_req", 32'(mem_req), 1);
    #2 rst_n = 0;
    #1;
    check("arst_req", 32'(mem_req), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_addr", mem_addr, 0);
    check("arst_ld", load_data, 0);
    e_ld = 0;
    @(posedge clk); #1;
    rst_n = 1; chk_en = 1;
    do_txn(0, 3'b100, 32'h103, 0, 0, 32'h9A000000, 0, 0, 0, 0);
    check("lit_post_rst_lbu", load_data, 32'h0000009A);
    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
